// File: rtl/rd_sweep_ctrl.sv
// Sweep sequencer for one rd_engine: derives per-point parameter words, starts the
// engine, gathers latency statistics and emits one result record per point.
module rd_sweep_ctrl #(
  parameter int PARAMS_BITS = 256,
  parameter int PTS_W       = 8,
  parameter int TO_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sweep_start,
  input  logic [PARAMS_BITS-1:0] base_params,
  input  logic [1:0]             sweep_mode,
  input  logic [PTS_W-1:0]       num_points,
  input  logic [TO_W-1:0]        timeout_cycles,
  output logic                   eng_start,
  output logic [PARAMS_BITS-1:0] eng_params,
  input  logic                   eng_end_of_exec,
  input  logic [63:0]            eng_lat_timer_sum,
  input  logic                   eng_lat_timer_valid,
  input  logic [15:0]            eng_lat_timer,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [PTS_W-1:0]       res_point,
  output logic [63:0]            res_cycles,
  output logic [15:0]            res_lat_min,
  output logic [15:0]            res_lat_max,
  output logic [31:0]            res_samples,
  output logic                   res_timeout,
  output logic                   sweep_busy,
  output logic                   sweep_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Replace the swept 32-bit field with (field << idx); shifts past 31 yield 0.
  function automatic logic [PARAMS_BITS-1:0] sweep_word(input logic [PARAMS_BITS-1:0] base,
                                                        input logic [1:0]             mode,
                                                        input logic [PTS_W-1:0]       idx);
    logic [PARAMS_BITS-1:0] w;
    w = base;
    case (mode)
      2'd0:    w[63:32]   = base[63:32] << idx;
      2'd1:    w[159:128] = base[159:128] << idx;
      2'd2:    w[31:0]    = base[31:0] << idx;
      default: w = base;
    endcase
    return w;
  endfunction

  logic [2:0]             state_q, state_d;
  logic [1:0]             setup_cnt_q, setup_cnt_d;
  logic [PTS_W-1:0]       i_q, i_d, num_q, num_d;
  logic [PARAMS_BITS-1:0] base_q, base_d, eng_params_q, eng_params_d;
  logic [1:0]             mode_q, mode_d;
  logic [TO_W-1:0]        to_lim_q, to_lim_d, to_cnt_q, to_cnt_d, to_next;
  logic [PTS_W-1:0]       i_next;
  logic                   eng_start_q, eng_start_d, res_valid_q, res_valid_d;
  logic                   res_timeout_q, res_timeout_d, busy_q, busy_d, done_q, done_d;
  logic [63:0]            res_cycles_q, res_cycles_d;
  logic [15:0]            lat_min_q, lat_min_d, lat_max_q, lat_max_d;
  logic [31:0]            samples_q, samples_d;

  always_comb begin
    state_d       = state_q;
    setup_cnt_d   = setup_cnt_q;
    i_d           = i_q;
    num_d         = num_q;
    base_d        = base_q;
    mode_d        = mode_q;
    to_lim_d      = to_lim_q;
    to_cnt_d      = to_cnt_q;
    eng_params_d  = eng_params_q;
    eng_start_d   = 1'b0;
    res_valid_d   = res_valid_q;
    res_timeout_d = res_timeout_q;
    res_cycles_d  = res_cycles_q;
    lat_min_d     = lat_min_q;
    lat_max_d     = lat_max_q;
    samples_d     = samples_q;
    done_d        = 1'b0;
    to_next       = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
    i_next        = i_q + {{(PTS_W-1){1'b0}}, 1'b1};
    case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          base_d   = base_params;
          mode_d   = sweep_mode;
          num_d    = num_points;
          to_lim_d = timeout_cycles;
          i_d      = '0;
          if (num_points == '0) begin
            state_d = S_DONE;
          end else begin
            state_d      = S_SETUP;
            setup_cnt_d  = 2'd1;
            eng_params_d = sweep_word(base_params, sweep_mode, '0);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        lat_min_d = 16'hFFFF;
        lat_max_d = 16'h0000;
        samples_d = 32'd0;
        // Entered from REPORT with count 0: the word is rebuilt first, then held two cycles.
        if (setup_cnt_q == 2'd0) begin
          eng_params_d = sweep_word(base_q, mode_q, i_q);
        end else begin
          eng_params_d = eng_params_q;
        end
        if (setup_cnt_q == 2'd2) begin
          state_d     = S_START;
          eng_start_d = 1'b1;
        end else begin
          setup_cnt_d = setup_cnt_q + 2'd1;
        end
      end
      S_START: begin
        to_cnt_d = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (eng_lat_timer_valid) begin
          lat_min_d = (eng_lat_timer < lat_min_q) ? eng_lat_timer : lat_min_q;
          lat_max_d = (eng_lat_timer > lat_max_q) ? eng_lat_timer : lat_max_q;
          samples_d = (samples_q == 32'hFFFF_FFFF) ? samples_q : samples_q + 32'd1;
        end else begin
          samples_d = samples_q;
        end
        if (eng_end_of_exec) begin
          res_cycles_d  = eng_lat_timer_sum;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = S_REPORT;
        end else if ((to_lim_q != '0) && (to_next == to_lim_q)) begin
          res_cycles_d  = {{(64-TO_W){1'b0}}, to_next};
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = S_REPORT;
        end else begin
          to_cnt_d = to_next;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (res_timeout_q || (i_next == num_q)) begin
            state_d = S_DONE;
          end else begin
            i_d         = i_next;
            setup_cnt_d = 2'd0;
            state_d     = S_SETUP;
          end
        end else begin
          state_d = S_REPORT;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      setup_cnt_q   <= 2'd0;
      i_q           <= '0;
      num_q         <= '0;
      base_q        <= '0;
      mode_q        <= 2'd0;
      to_lim_q      <= '0;
      to_cnt_q      <= '0;
      eng_params_q  <= '0;
      eng_start_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_cycles_q  <= 64'd0;
      lat_min_q     <= 16'hFFFF;
      lat_max_q     <= 16'h0000;
      samples_q     <= 32'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      setup_cnt_q   <= setup_cnt_d;
      i_q           <= i_d;
      num_q         <= num_d;
      base_q        <= base_d;
      mode_q        <= mode_d;
      to_lim_q      <= to_lim_d;
      to_cnt_q      <= to_cnt_d;
      eng_params_q  <= eng_params_d;
      eng_start_q   <= eng_start_d;
      res_valid_q   <= res_valid_d;
      res_timeout_q <= res_timeout_d;
      res_cycles_q  <= res_cycles_d;
      lat_min_q     <= lat_min_d;
      lat_max_q     <= lat_max_d;
      samples_q     <= samples_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign eng_start   = eng_start_q;
  assign eng_params  = eng_params_q;
  assign res_valid   = res_valid_q;
  assign res_point   = i_q;
  assign res_cycles  = res_cycles_q;
  assign res_lat_min = lat_min_q;
  assign res_lat_max = lat_max_q;
  assign res_samples = samples_q;
  assign res_timeout = res_timeout_q;
  assign sweep_busy  = busy_q;
  assign sweep_done  = done_q;

endmodule

// File: tb/tb_rd_sweep_ctrl.sv
// Directed bench for rd_sweep_ctrl: a simple engine model plus a scoreboard of
// expected result records checked at each handshake.
module tb_rd_sweep_ctrl;

  localparam logic [63:0] SUM_BASE = 64'hA5A5_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sweep_start;
  logic [255:0] base_params;
  logic [1:0]   sweep_mode;
  logic [7:0]   num_points;
  logic [31:0]  timeout_cycles;
  logic         eng_start;
  logic [255:0] eng_params;
  logic         eng_end_of_exec = 1'b0;
  logic [63:0]  eng_lat_timer_sum = 64'd0;
  logic         eng_lat_timer_valid = 1'b0;
  logic [15:0]  eng_lat_timer = 16'd0;
  logic         res_valid;
  logic         res_ready;
  logic [7:0]   res_point;
  logic [63:0]  res_cycles;
  logic [15:0]  res_lat_min, res_lat_max;
  logic [31:0]  res_samples;
  logic         res_timeout, sweep_busy, sweep_done;

  always #5 clk = ~clk;

  rd_sweep_ctrl #(.PARAMS_BITS(256), .PTS_W(8), .TO_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .sweep_start(sweep_start), .base_params(base_params),
    .sweep_mode(sweep_mode), .num_points(num_points), .timeout_cycles(timeout_cycles),
    .eng_start(eng_start), .eng_params(eng_params), .eng_end_of_exec(eng_end_of_exec),
    .eng_lat_timer_sum(eng_lat_timer_sum), .eng_lat_timer_valid(eng_lat_timer_valid),
    .eng_lat_timer(eng_lat_timer), .res_valid(res_valid), .res_ready(res_ready),
    .res_point(res_point), .res_cycles(res_cycles), .res_lat_min(res_lat_min),
    .res_lat_max(res_lat_max), .res_samples(res_samples), .res_timeout(res_timeout),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done)
  );

  typedef struct packed {
    logic [7:0]   point;
    logic [63:0]  cycles;
    logic [15:0]  mn;
    logic [15:0]  mx;
    logic [31:0]  samples;
    logic         tmo;
    logic [255:0] params;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  longint cyc = 0;

  // Per-point engine behaviour, written only by the stimulus block.
  int          delay_tab[256];
  int          nstrb = 0;
  int          strb_at[3];
  logic [15:0] strb_lat[3];

  // Engine model state, written only by the engine process.
  int           e_cnt = 0;
  int           e_delay = 0;
  bit           e_run = 1'b0;
  int           n_starts = 0;
  longint       eoe_cyc = 0;
  logic [255:0] start_params = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: driven on the falling edge; a delay of 0 means the engine never finishes.
  always @(negedge clk) begin
    eng_end_of_exec     = 1'b0;
    eng_lat_timer_valid = 1'b0;
    if (!rst_n) begin
      e_run = 1'b0;
    end else if (eng_start) begin
      n_starts++;
      start_params = eng_params;
      e_cnt   = 0;
      e_run   = 1'b1;
      e_delay = delay_tab[res_point];
    end else if (e_run) begin
      e_cnt++;
      for (int k = 0; k < 3; k++) begin
        if (k < nstrb && strb_at[k] == e_cnt) begin
          eng_lat_timer_valid = 1'b1;
          eng_lat_timer       = strb_lat[k];
        end
      end
      if (e_delay != 0 && e_cnt == e_delay) begin
        eng_end_of_exec   = 1'b1;
        eng_lat_timer_sum = SUM_BASE + 64'(e_delay);
        eoe_cyc = cyc;
        e_run   = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_eng_start"}, eng_start, 1'b0);
    check({tag, "_res_valid"}, res_valid, 1'b0);
    check({tag, "_busy"}, sweep_busy, 1'b0);
    check({tag, "_done"}, sweep_done, 1'b0);
    check({tag, "_timeout"}, res_timeout, 1'b0);
    check({tag, "_params"}, eng_params, 256'd0);
    check({tag, "_cycles"}, res_cycles, 64'd0);
    check({tag, "_min"}, res_lat_min, 16'hFFFF);
    check({tag, "_max"}, res_lat_max, 16'd0);
    check({tag, "_samples"}, res_samples, 32'd0);
    check({tag, "_point"}, res_point, 8'd0);
  endtask

  task automatic push(input logic [7:0] pt, input logic [63:0] cy, input logic [15:0] mn,
                      input logic [15:0] mx, input logic [31:0] sm, input logic tmo,
                      input logic [255:0] p);
    rec_t r;
    r.point = pt; r.cycles = cy; r.mn = mn; r.mx = mx; r.samples = sm; r.tmo = tmo; r.params = p;
    exp_q.push_back(r);
  endtask

  // Issue a sweep at a falling edge and check the start-up latencies.
  task automatic start_sweep(input logic [255:0] base, input logic [1:0] mode, input logic [7:0] num,
                             input logic [31:0] to, input logic [255:0] exp_p0);
    int s0;
    s0 = n_starts;
    base_params = base; sweep_mode = mode; num_points = num; timeout_cycles = to;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    base_params = '0;
    check("busy_rise", sweep_busy, 1'b1);
    if (num != 8'd0) check("params_at_1", eng_params, exp_p0);
    @(negedge clk);
    check("start_not_at_2", eng_start, 1'b0);
    if (num == 8'd0) begin
      check("empty_done_at_2", sweep_done, 1'b1);
      repeat (4) @(negedge clk);
      check("empty_no_start", n_starts, s0);
    end else begin
      @(negedge clk);
      check("start_at_3", eng_start, 1'b1);
    end
  endtask

  // Wait for a record, compare it with the scoreboard, optionally stall, then handshake.
  task automatic collect(input int bp, input bit more);
    rec_t e;
    int   n;
    bit   ok;
    bit   v1;
    n = 0;
    while (!res_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      check("res_valid_wait", res_valid, 1'b1);
      return;
    end
    check("sb_nonempty", exp_q.size() != 0, 1'b1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    if (!e.tmo) check("valid_latency", cyc, eoe_cyc + 1);
    check("point", res_point, e.point);
    check("cycles", res_cycles, e.cycles);
    check("lat_min", res_lat_min, e.mn);
    check("lat_max", res_lat_max, e.mx);
    check("samples", res_samples, e.samples);
    check("timeout", res_timeout, e.tmo);
    check("params", start_params, e.params);
    ok = 1'b1;
    repeat (bp) begin
      @(negedge clk);
      if (!res_valid || res_point != e.point || res_cycles != e.cycles || res_lat_min != e.mn ||
          res_lat_max != e.mx || res_samples != e.samples || res_timeout != e.tmo ||
          eng_start || eng_params != e.params) ok = 1'b0;
    end
    if (bp > 0) check("bp_stable", ok, 1'b1);
    res_ready = 1'b1;
    n = 0;
    v1 = 1'b0;
    do begin
      @(negedge clk);
      res_ready = 1'b0;
      n++;
      if (n == 1) v1 = res_valid;
    end while (!(more ? eng_start : sweep_done) && n < 20);
    check("valid_drop", v1, 1'b0);
    if (more) check("next_start_lat", n, 4);
    else begin
      check("done_lat", n, 2);
      check("busy_fall", sweep_busy, 1'b0);
    end
  endtask

  initial begin
    logic [255:0] base, p;
    logic [31:0]  stride_exp [4];
    int           s0;
    stride_exp[0] = 32'd64; stride_exp[1] = 32'd128; stride_exp[2] = 32'd256; stride_exp[3] = 32'd512;
    for (int k = 0; k < 256; k++) delay_tab[k] = 0;
    rst_n = 1'b0; sweep_start = 1'b0; res_ready = 1'b0;
    base_params = '0; sweep_mode = 2'd0; num_points = 8'd0; timeout_cycles = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");

    // Empty sweep.
    start_sweep(256'h1234, 2'd0, 8'd0, 32'd0, 256'd0);

    // Stride sweep, 4 points of 100 cycles.
    base = '0;
    base[31:0] = 32'd7; base[63:32] = 32'd64; base[127:64] = 64'd1000;
    base[159:128] = 32'd16; base[192:160] = 33'h1_0000_0040; base[224] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      delay_tab[k] = 100;
      p = base; p[63:32] = stride_exp[k];
      push(8'(k), SUM_BASE + 64'd100, 16'hFFFF, 16'd0, 32'd0, 1'b0, p);
    end
    p = base;
    start_sweep(base, 2'd0, 8'd4, 32'd0, p);
    for (int k = 0; k < 4; k++) collect(0, k != 3);

    // Stats with backpressure on point 0; point 1 has no strobes.
    base = 256'hDEAD_BEEF_0123_4567_89AB_CDEF;
    delay_tab[0] = 30; delay_tab[1] = 20;
    strb_at[0] = 10; strb_lat[0] = 16'd40;
    strb_at[1] = 20; strb_lat[1] = 16'd25;
    strb_at[2] = 30; strb_lat[2] = 16'd90;
    nstrb = 3;
    push(8'd0, SUM_BASE + 64'd30, 16'd25, 16'd90, 32'd3, 1'b0, base);
    push(8'd1, SUM_BASE + 64'd20, 16'hFFFF, 16'd0, 32'd0, 1'b0, base);
    start_sweep(base, 2'd3, 8'd2, 32'd0, base);
    collect(50, 1'b1);
    nstrb = 0;
    collect(0, 1'b0);

    // Timeout on point 1 of 3 in a burst sweep.
    base = '0; base[159:128] = 32'd3; base[63:32] = 32'd9;
    delay_tab[0] = 50; delay_tab[1] = 0; delay_tab[2] = 50;
    s0 = n_starts;
    p = base;
    push(8'd0, SUM_BASE + 64'd50, 16'hFFFF, 16'd0, 32'd0, 1'b0, p);
    p[159:128] = 32'd6;
    push(8'd1, 64'd200, 16'hFFFF, 16'd0, 32'd0, 1'b1, p);
    start_sweep(base, 2'd1, 8'd3, 32'd200, base);
    collect(0, 1'b1);
    collect(0, 1'b0);
    repeat (10) @(negedge clk);
    check("tmo_no_point2", n_starts - s0, 2);

    // Top stride bit shifted out at i = 1.
    base = '0; base[63:32] = 32'h8000_0000; base[31:0] = 32'd3;
    delay_tab[0] = 5; delay_tab[1] = 5;
    p = base;
    push(8'd0, SUM_BASE + 64'd5, 16'hFFFF, 16'd0, 32'd0, 1'b0, p);
    p[63:32] = 32'd0;
    push(8'd1, SUM_BASE + 64'd5, 16'hFFFF, 16'd0, 32'd0, 1'b0, p);
    start_sweep(base, 2'd0, 8'd2, 32'd0, base);
    collect(0, 1'b1);
    collect(0, 1'b0);

    // Reset in the middle of a running point, then a fresh wg_size sweep.
    base = '0; base[31:0] = 32'd5;
    delay_tab[0] = 0;
    start_sweep(base, 2'd2, 8'd2, 32'd0, base);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    delay_tab[0] = 7; delay_tab[1] = 7;
    p = base;
    push(8'd0, SUM_BASE + 64'd7, 16'hFFFF, 16'd0, 32'd0, 1'b0, p);
    p[31:0] = 32'd10;
    push(8'd1, SUM_BASE + 64'd7, 16'hFFFF, 16'd0, 32'd0, 1'b0, p);
    start_sweep(base, 2'd2, 8'd2, 32'd0, base);
    collect(0, 1'b1);
    collect(0, 1'b0);
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
